// File: rtl/uart_rx_if.sv
// Serial-line side of the UART receiver: the rx line in, the recovered word and status strobes out.
// The line driver takes the master modport and the receiver takes the slave modport.
interface uart_rx_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  rx;
   logic [DATA_WIDTH-1:0] dout;
   logic                  done_rx;
   logic                  frame_err;
   logic                  busy;

   modport master (
      output rx,
      input  dout,
      input  done_rx,
      input  frame_err,
      input  busy
   );

   modport slave (
      input  rx,
      output dout,
      output done_rx,
      output frame_err,
      output busy
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling; done_rx rises ~991 clk after the start edge at defaults.
// No backpressure: each word is strobed once on done_rx and dout holds it until the next good frame.
module uart_rx #(
   parameter int clk_freq   = 1000000,
   parameter int baudrate   = 9600,
   parameter int DATA_WIDTH = 8
) (
   input  logic     clk,
   input  logic     reset,
   uart_rx_if.slave bus
);

   localparam int CLKS_PER_BIT = clk_freq / baudrate;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
   localparam int IDX_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } state_t;

   state_t                state_q,  state_d;
   logic [CNT_W-1:0]      cnt_q,    cnt_d;
   logic [IDX_W-1:0]      bitidx_q, bitidx_d;
   logic [DATA_WIDTH-1:0] shreg_q,  shreg_d;
   logic [DATA_WIDTH-1:0] dout_q,   dout_d;
   logic                  done_q,   done_d;
   logic                  ferr_q,   ferr_d;
   logic                  sync1_q,  sync1_d;
   logic                  sync2_q,  sync2_d;
   logic                  rx_s;

   assign rx_s = sync2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bitidx_q <= '0;
         shreg_q  <= '0;
         dout_q   <= '0;
         done_q   <= 1'b0;
         ferr_q   <= 1'b0;
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bitidx_q <= bitidx_d;
         shreg_q  <= shreg_d;
         dout_q   <= dout_d;
         done_q   <= done_d;
         ferr_q   <= ferr_d;
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bitidx_d = bitidx_q;
      shreg_d  = shreg_q;
      dout_d   = dout_q;
      done_d   = 1'b0;
      ferr_d   = 1'b0;
      sync1_d  = bus.rx;
      sync2_d  = sync1_q;
      case (state_q)
         IDLE: begin
            cnt_d    = '0;
            bitidx_d = '0;
            if (!rx_s) state_d = START;
         end
         START: begin
            // A start bit still low at its centre is real; otherwise it was a glitch.
            if (cnt_q == HALF_LAST) begin
               cnt_d    = '0;
               bitidx_d = '0;
               state_d  = rx_s ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d            = '0;
               shreg_d[bitidx_q] = rx_s;
               if (bitidx_q == IDX_LAST) state_d  = STOP;
               else                      bitidx_d = bitidx_q + IDX_W'(1);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STOP: begin
            // Leaving at the stop-bit centre leaves half a bit to catch a back-to-back start edge.
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  dout_d  = shreg_q;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = WAIT_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT_IDLE: begin
            cnt_d = '0;
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.busy      = (state_q != IDLE);
      bus.dout      = dout_q;
      bus.done_rx   = done_q;
      bus.frame_err = ferr_q;
   end

endmodule
